// File: rtl/binary_cell_pkg.sv
// Shared constants for the binary-cell storage hierarchy (cell -> register -> RAM).
// A register is a DATA_W-bit cell, and every stored bit resets to RESET_BIT.
package binary_cell_pkg;

   localparam int DATA_W = 16;
   localparam logic RESET_BIT = 1'b0;
   localparam logic [DATA_W-1:0] RESET_VAL = '0;

   // Write happens only when the cell is selected and write-enabled.
   function automatic logic load_sel(input logic cs, input logic w);
      return cs & w;
   endfunction

   // Read data is driven only when the cell is selected and read-enabled.
   function automatic logic read_sel(input logic cs, input logic r);
      return cs & r;
   endfunction

endpackage

// File: rtl/binary_cell_if.sv
// Data/control bundle of one binary cell. The master drives data and strobes,
// and the slave (the cell) returns the gated read data.
interface binary_cell_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] DIn;
   logic             cs;
   logic             w;
   logic             r;
   logic [WIDTH-1:0] DOut;

   modport master (output DIn, output cs, output w, output r, input DOut);
   modport slave  (input DIn, input cs, input w, input r, output DOut);
endinterface

// File: rtl/binary_cell_d_flip_flop_areset.sv
// Single-bit rising-edge D flip-flop with asynchronous active-low reset.
// It has true and complement outputs.
module d_flip_flop_areset
   import binary_cell_pkg::*;
#(
   parameter logic RST_VAL = RESET_BIT
) (
   input  logic D,
   input  logic clk,
   input  logic re,
   output logic q,
   output logic q_
);

   always_ff @(posedge clk or negedge re) begin
      if (!re) q <= RST_VAL;
      else     q <= D;
   end

   assign q_ = ~q;

endmodule

// File: rtl/binary_cell.sv
// WIDTH-bit storage cell. The flip-flops feed back through a load mux, and the
// read data goes through a gate that drives 0 when the cell is not being read.
module binary_cell
   import binary_cell_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic          clk,
   input  logic          re,
   binary_cell_if.slave  bus
);

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_n;
   logic             load;
   logic             read;

   assign load = load_sel(bus.cs, bus.w);
   assign read = read_sel(bus.cs, bus.r);
   assign d    = load ? bus.DIn : q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_flip_flop_areset #(.RST_VAL(RESET_BIT)) u_ff (
         .D   (d[i]),
         .clk (clk),
         .re  (re),
         .q   (q[i]),
         .q_  (q_n[i])
      );
   end

   // The read path has no bypass from DIn. A write becomes visible on DOut only after the edge.
   assign bus.DOut = read ? q : '0;

   ff_complement_ok: assert property (@(posedge clk) q_n == ~q);

endmodule

// File: tb/tb_binary_cell.sv
// Directed bench for binary_cell (WIDTH=1 and WIDTH=16) and a stand-alone flip-flop.
// Inputs change on the falling edge, and outputs are sampled 1 unit after the rising edge.
module tb_binary_cell;
   import binary_cell_pkg::*;

   logic clk;
   logic re;
   int   tests;
   int   fails;

   logic ff_d, ff_re, ff_q, ff_qn;

   binary_cell_if #(.WIDTH(1))      bus1 ();
   binary_cell_if #(.WIDTH(DATA_W)) bus16 ();

   binary_cell #(.WIDTH(1)) dut1 (
      .clk (clk),
      .re  (re),
      .bus (bus1.slave)
   );

   binary_cell #(.WIDTH(DATA_W)) dut16 (
      .clk (clk),
      .re  (re),
      .bus (bus16.slave)
   );

   d_flip_flop_areset u_ff (
      .D   (ff_d),
      .clk (clk),
      .re  (ff_re),
      .q   (ff_q),
      .q_  (ff_qn)
   );

   initial clk = 1'b0;
   always #3 clk = ~clk;

   task automatic chk1(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic test_reset();
      re = 1'b0;
      ff_re = 1'b0;
      ff_d = 1'b1;
      bus1.DIn = 1'b1; bus1.cs = 1'b1; bus1.w = 1'b1; bus1.r = 1'b1;
      bus16.DIn = 16'hFFFF; bus16.cs = 1'b1; bus16.w = 1'b1; bus16.r = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++;
         if (bus1.DOut !== 1'b0) begin
            fails++;
            $display("FAIL reset_dout1: got %b expected 0", bus1.DOut);
         end
         tests++;
         if (bus16.DOut !== 16'h0000) begin
            fails++;
            $display("FAIL reset_dout16: got %h expected 0000", bus16.DOut);
         end
         tests++;
         if (ff_q !== 1'b0 || ff_qn !== 1'b1) begin
            fails++;
            $display("FAIL reset_ff: got q=%b q_=%b expected q=0 q_=1", ff_q, ff_qn);
         end
      end
   endtask

   task automatic test_deselected_write();
      @(negedge clk);
      re = 1'b1;
      bus1.cs = 1'b0; bus1.w = 1'b1; bus1.DIn = 1'b1; bus1.r = 1'b0;
      bus16.cs = 1'b0; bus16.w = 1'b1; bus16.DIn = 16'hBEEF; bus16.r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            @(negedge clk);
            bus1.r = 1'b1;
            bus16.r = 1'b1;
         end
         @(posedge clk); #1;
         tests++;
         if (bus1.DOut !== 1'b0) begin
            fails++;
            $display("FAIL desel_dout1: got %b expected 0 (edge %0d)", bus1.DOut, i);
         end
         tests++;
         if (bus16.DOut !== 16'h0000) begin
            fails++;
            $display("FAIL desel_dout16: got %h expected 0000 (edge %0d)", bus16.DOut, i);
         end
      end
      // Select the cell without writing to show that the stored value stayed 0.
      @(negedge clk);
      bus1.cs = 1'b1; bus1.w = 1'b0;
      bus16.cs = 1'b1; bus16.w = 1'b0;
      #1;
      tests++;
      if (bus1.DOut !== 1'b0) begin
         fails++;
         $display("FAIL desel_stored1: got %b expected 0", bus1.DOut);
      end
      tests++;
      if (bus16.DOut !== 16'h0000) begin
         fails++;
         $display("FAIL desel_stored16: got %h expected 0000", bus16.DOut);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      bus1.cs = 1'b1; bus1.w = 1'b1; bus1.r = 1'b0; bus1.DIn = 1'b0;
      @(posedge clk); #1;
      chk1("wr_r0_dout", bus1.DOut, 1'b0);
      @(negedge clk);
      bus1.DIn = 1'b1; bus1.r = 1'b1;
      #1;
      chk1("wr_no_bypass", bus1.DOut, 1'b0);
      @(posedge clk); #1;
      chk1("wr_after_edge", bus1.DOut, 1'b1);

      @(negedge clk);
      bus16.cs = 1'b1; bus16.w = 1'b1; bus16.r = 1'b1; bus16.DIn = 16'd45;
      @(posedge clk); #1;
      tests++;
      if (bus16.DOut !== 16'd45) begin
         fails++;
         $display("FAIL wr16_45: got %0d expected 45", bus16.DOut);
      end
      @(negedge clk);
      bus16.DIn = 16'd64;
      #1;
      tests++;
      if (bus16.DOut !== 16'd45) begin
         fails++;
         $display("FAIL wr16_pre64: got %0d expected 45", bus16.DOut);
      end
      @(posedge clk); #1;
      tests++;
      if (bus16.DOut !== 16'd64) begin
         fails++;
         $display("FAIL wr16_64: got %0d expected 64", bus16.DOut);
      end
      // Mixed bit pattern to check that every bit lane is independent.
      @(negedge clk);
      bus16.DIn = 16'hA5C3;
      @(posedge clk); #1;
      tests++;
      if (bus16.DOut !== 16'hA5C3) begin
         fails++;
         $display("FAIL wr16_pattern: got %h expected a5c3", bus16.DOut);
      end
      @(negedge clk);
      bus16.DIn = 16'h5A3C;
      @(posedge clk); #1;
      tests++;
      if (bus16.DOut !== 16'h5A3C) begin
         fails++;
         $display("FAIL wr16_invpattern: got %h expected 5a3c", bus16.DOut);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      bus1.cs = 1'b1; bus1.w = 1'b0; bus1.r = 1'b1; bus1.DIn = 1'b0;
      bus16.w = 1'b0; bus16.DIn = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk1("hold_w0", bus1.DOut, 1'b1);
      end
      tests++;
      if (bus16.DOut !== 16'h5A3C) begin
         fails++;
         $display("FAIL hold16: got %h expected 5a3c", bus16.DOut);
      end
      @(negedge clk);
      bus1.cs = 1'b0;
      #1;
      chk1("hold_cs0_gate", bus1.DOut, 1'b0);
      bus1.cs = 1'b1; bus1.r = 1'b0;
      #1;
      chk1("hold_r0_gate", bus1.DOut, 1'b0);
      bus1.r = 1'b1;
      #1;
      chk1("hold_reselect", bus1.DOut, 1'b1);
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #1 re = 1'b0;
      #1;
      chk1("areset_immediate", bus1.DOut, 1'b0);
      tests++;
      if (bus16.DOut !== 16'h0000) begin
         fails++;
         $display("FAIL areset16: got %h expected 0000", bus16.DOut);
      end
      @(negedge clk);
      re = 1'b1;
      bus1.w = 1'b1; bus1.DIn = 1'b1;
      #1;
      chk1("areset_release_no_edge", bus1.DOut, 1'b0);
      @(posedge clk); #1;
      chk1("areset_first_capture", bus1.DOut, 1'b1);
   endtask

   task automatic test_flip_flop();
      logic [3:0] pat;
      pat = 4'b1010;
      @(negedge clk);
      ff_re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ff_d = pat[i];
         @(posedge clk); #1;
         tests++;
         if (ff_q !== pat[i] || ff_qn !== ~pat[i]) begin
            fails++;
            $display("FAIL ff_follow[%0d]: got q=%b q_=%b expected q=%b q_=%b",
                     i, ff_q, ff_qn, pat[i], ~pat[i]);
         end
      end
      // ff_q is 1 here. Pulse reset for 5 units, and let one rising edge land inside the pulse.
      @(negedge clk);
      ff_re = 1'b0;
      #1;
      chk1("ff_areset_q", ff_q, 1'b0);
      chk1("ff_areset_qn", ff_qn, 1'b1);
      #4 ff_re = 1'b1;
      #1;
      chk1("ff_after_pulse", ff_q, 1'b0);
      @(posedge clk); #1;
      chk1("ff_recapture", ff_q, 1'b1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_deselected_write();
      test_write_read();
      test_hold();
      test_async_reset();
      test_flip_flop();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, expected test sequence to complete");
      $fatal(1);
   end

endmodule
